// File: rtl/queue_flex_if.sv
// rtl/queue_flex_if.sv - REQ/ACK producer and consumer handshake bundle for queue_flex
//
// Purpose: groups the write-side and read-side handshake and data signals.
// Signals:
//   dInREQ  - queue can accept a word (queue -> producer)
//   dInACK  - producer presents a valid word on dIN
//   dIN     - write data, BitWidth bits
//   dOutACK - a valid word is on dOUT (queue -> consumer)
//   dOutREQ - consumer takes the word on dOUT
//   dOUT    - head-of-queue data, BitWidth bits
// Modports: slave = the queue itself, master = the surrounding producer/consumer side.
interface queue_flex_if #(
  parameter int BitWidth = 32
);
  logic                dInREQ;
  logic                dInACK;
  logic [BitWidth-1:0] dIN;
  logic                dOutACK;
  logic                dOutREQ;
  logic [BitWidth-1:0] dOUT;

  modport slave (
    output dInREQ,
    input  dInACK,
    input  dIN,
    output dOutACK,
    input  dOutREQ,
    output dOUT
  );

  modport master (
    input  dInREQ,
    output dInACK,
    output dIN,
    input  dOutACK,
    output dOutREQ,
    input  dOUT
  );
endinterface

// File: rtl/queue_flex.sv
// rtl/queue_flex.sv - any-depth first-word-fall-through FIFO with occupancy count and flags
//
// Purpose: FIFO of BufferDepth entries (any depth >= 2) with explicit occupancy
// count, almost-full/almost-empty thresholds, synchronous flush and a last-entry flag.
// Optional feature macro: QUEUE_FLEX_ERR_FLAGS_EN adds sticky ErrOverflow/ErrUnderflow.
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - synchronous reset, active low
//   flush        - synchronous clear of pointers and count, active high
//   bus          - queue_flex_if.slave handshake bundle (dInREQ/dInACK/dIN, dOutACK/dOutREQ/dOUT)
//   Count        - current occupancy 0..BufferDepth
//   BufferFull   - Count == BufferDepth
//   BufferEmpty  - Count == 0
//   OnLastEntry  - Count == 1
//   AlmostFull   - Count >= AlmostFullLevel
//   AlmostEmpty  - Count <= AlmostEmptyLevel
//   ErrOverflow  - (macro only) sticky: write attempted while full
//   ErrUnderflow - (macro only) sticky: read attempted while empty
module queue_flex #(
  parameter int BitWidth         = 32,
  parameter int BufferDepth      = 6,
  parameter int AlmostFullLevel  = BufferDepth - 1,
  parameter int AlmostEmptyLevel = 1,
  localparam int PtrW            = $clog2(BufferDepth),
  localparam int CntW            = $clog2(BufferDepth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  queue_flex_if.slave     bus,
  output logic [CntW-1:0] Count,
  output logic            BufferFull,
  output logic            BufferEmpty,
  output logic            OnLastEntry,
  output logic            AlmostFull,
  output logic            AlmostEmpty
`ifdef QUEUE_FLEX_ERR_FLAGS_EN
  ,
  output logic            ErrOverflow,
  output logic            ErrUnderflow
`endif
);

  localparam logic [CntW-1:0] DepthC   = CntW'(BufferDepth);
  localparam logic [CntW-1:0] AfLevelC = CntW'(AlmostFullLevel);
  localparam logic [CntW-1:0] AeLevelC = CntW'(AlmostEmptyLevel);
  localparam logic [PtrW-1:0] LastPtrC = PtrW'(BufferDepth - 1);

  generate
    if (BufferDepth < 2) begin : g_bad_depth
      $error("queue_flex: BufferDepth must be 2 or more");
    end
    if (AlmostFullLevel > BufferDepth) begin : g_bad_af
      $error("queue_flex: AlmostFullLevel must not exceed BufferDepth");
    end
    if (AlmostEmptyLevel >= BufferDepth) begin : g_bad_ae
      $error("queue_flex: AlmostEmptyLevel must be below BufferDepth");
    end
  endgenerate

  logic [BitWidth-1:0] r_mem [BufferDepth];
  logic [PtrW-1:0]     r_waddr;
  logic [PtrW-1:0]     r_raddr;
  logic [CntW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_wen;
  logic w_ren;
  logic w_keep;

  // Flags decode only from the registered count, never from pointer compare.
  assign w_full  = (r_count == DepthC);
  assign w_empty = (r_count == '0);

  assign bus.dInREQ  = !w_full;
  assign bus.dOutACK = !w_empty;
  assign bus.dOUT    = r_mem[r_raddr];

  assign w_wen  = bus.dInACK && !w_full;
  assign w_ren  = bus.dOutREQ && !w_empty;
  // Handshakes only take effect when neither reset nor flush is active.
  assign w_keep = rst && !flush;

  assign Count       = r_count;
  assign BufferFull  = w_full;
  assign BufferEmpty = w_empty;
  assign OnLastEntry = (r_count == CntW'(1));
  assign AlmostFull  = (r_count >= AfLevelC);
  assign AlmostEmpty = (r_count <= AeLevelC);

  // Explicit wrap at BufferDepth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == LastPtrC) ? '0 : p + PtrW'(1);
  endfunction

  // Storage has no reset; a write during reset or flush is discarded.
  always_ff @(posedge clk) begin
    if (w_keep && w_wen) begin
      r_mem[r_waddr] <= bus.dIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_wen) begin
        r_waddr <= ptr_next(r_waddr);
      end
      if (w_ren) begin
        r_raddr <= ptr_next(r_raddr);
      end
      if (w_wen && !w_ren) begin
        r_count <= r_count + CntW'(1);
      end else if (w_ren && !w_wen) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

`ifdef QUEUE_FLEX_ERR_FLAGS_EN
  logic r_err_ovf;
  logic r_err_unf;

  // Sticky error capture of illegal attempts; the handshake itself ignores them.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (bus.dInACK && w_full) begin
        r_err_ovf <= 1'b1;
      end
      if (bus.dOutREQ && w_empty) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  assign ErrOverflow  = r_err_ovf;
  assign ErrUnderflow = r_err_unf;
`endif

endmodule

// File: tb/tb_queue_flex.sv
// tb/tb_queue_flex.sv - self-checking bench for queue_flex against a queue-based model
module tb_queue_flex;
  localparam int BW    = 32;
  localparam int DEPTH = 6;
  localparam int AFL   = DEPTH - 1;
  localparam int AEL   = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] Count;
  logic          BufferFull;
  logic          BufferEmpty;
  logic          OnLastEntry;
  logic          AlmostFull;
  logic          AlmostEmpty;
`ifdef QUEUE_FLEX_ERR_FLAGS_EN
  logic          ErrOverflow;
  logic          ErrUnderflow;
`endif

  queue_flex_if #(.BitWidth(BW)) bus ();

  queue_flex #(
    .BitWidth(BW),
    .BufferDepth(DEPTH),
    .AlmostFullLevel(AFL),
    .AlmostEmptyLevel(AEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus.slave),
    .Count(Count),
    .BufferFull(BufferFull),
    .BufferEmpty(BufferEmpty),
    .OnLastEntry(OnLastEntry),
    .AlmostFull(AlmostFull),
    .AlmostEmpty(AlmostEmpty)
`ifdef QUEUE_FLEX_ERR_FLAGS_EN
    ,
    .ErrOverflow(ErrOverflow),
    .ErrUnderflow(ErrUnderflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BW-1:0] model_q[$];
  logic          model_ovf = 1'b0;
  logic          model_unf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int n;
    n = model_q.size();
    check("count", 64'(Count), 64'(n));
    check("full", 64'(BufferFull), 64'(n == DEPTH));
    check("empty", 64'(BufferEmpty), 64'(n == 0));
    check("last", 64'(OnLastEntry), 64'(n == 1));
    check("afull", 64'(AlmostFull), 64'(n >= AFL));
    check("aempty", 64'(AlmostEmpty), 64'(n <= AEL));
    check("din_req", 64'(bus.dInREQ), 64'(n < DEPTH));
    check("dout_ack", 64'(bus.dOutACK), 64'(n > 0));
    if (n > 0) begin
      check("dout", 64'(bus.dOUT), 64'(model_q[0]));
    end
`ifdef QUEUE_FLEX_ERR_FLAGS_EN
    check("err_ovf", 64'(ErrOverflow), 64'(model_ovf));
    check("err_unf", 64'(ErrUnderflow), 64'(model_unf));
`endif
  endtask

  // Drive one cycle: inputs applied #1 after an edge, outputs checked, then the
  // model advances by the same rules the queue must follow at the next edge.
  task automatic cycle(input logic ack, input logic [BW-1:0] d, input logic req,
                       input logic fl, input logic rs);
    int  n;
    logic do_w;
    logic do_r;
    bus.dInACK  = ack;
    bus.dIN     = d;
    bus.dOutREQ = req;
    flush       = fl;
    rst         = rs;
    compare_outputs();
    n = model_q.size();
    if (!rs || fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      do_w = ack && (n < DEPTH);
      do_r = req && (n > 0);
      if (ack && n == DEPTH) model_ovf = 1'b1;
      if (req && n == 0) model_unf = 1'b1;
      if (do_r) void'(model_q.pop_front());
      if (do_w) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.dInACK  = 1'b0;
    bus.dIN     = '0;
    bus.dOutREQ = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset state, then fill to full and try a 7th write.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, BW'(32'h11 + i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, BW'(32'h77), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Simultaneous write/read at Count=3 across the pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, BW'(32'h100 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 3; i < 23; i++) cycle(1'b1, BW'(32'h100 + i), 1'b1, 1'b0, 1'b1);

    // Flush at Count=4 with both handshakes active.
    cycle(1'b1, BW'(32'h200), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, BW'(32'hDEAD), 1'b1, 1'b1, 1'b1);
    cycle(1'b1, BW'(32'h300), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Underflow attempt on an empty queue, held across idle cycles, then flushed.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Reset for one cycle mid-stream at Count=3.
    for (int i = 0; i < 3; i++) cycle(1'b1, BW'(32'h400 + i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, BW'(32'hBEEF), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), BW'($urandom),
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) >= 2));
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
